// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
package sw_debounce_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 4;
    localparam int CNT_W            = 4;

    // True when this differing sample completes the qualification run.
    function automatic logic qualified(input logic [CNT_W-1:0] cnt, input int stable);
        return ((32'(cnt) + 32'd1) == 32'(stable));
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounced switch bit: qualification counter, accepted state and edge pulses.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_BIT    = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tick_i,
    input  logic bypass_i,
    input  logic sync_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o,
    output logic pulse_next_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Next-state: bypass tracks the input, otherwise only tick samples can move the state.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (bypass_i) begin
            cnt_d   = '0;
            state_d = sync_i;
        end else if (tick_i) begin
            if (sync_i != state_q) begin
                if (qualified(cnt_q, STABLE_TICKS)) begin
                    cnt_d   = '0;
                    state_d = ~state_q;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end else begin
            cnt_d   = cnt_q;
            state_d = state_q;
        end
        rise_d = state_d & ~state_q;
        fall_d = ~state_d & state_q;
    end

    // State, counter and pulse registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            state_q <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state_o      = state_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign pulse_next_o = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce.sv
// Multi-bit switch debouncer: synchronizer, shared sample prescaler, per-bit qualifiers.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               TICK_DIV     = DEF_TICK_DIV,
    parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             bypass,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             change
);

    localparam int             PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0]  ps_q, ps_d;
    logic             tick_s;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] pulse_next_s;
    logic             change_q;

    // Prescaler wrap and sample tick.
    always_comb begin
        tick_s = (ps_q == PS_LAST);
        if (tick_s) begin
            ps_d = '0;
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    // Prescaler, two-flop synchronizer and aggregate change pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q     <= '0;
            sync1_q  <= RESET_VALUE;
            sync2_q  <= RESET_VALUE;
            change_q <= 1'b0;
        end else begin
            ps_q     <= ps_d;
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            change_q <= |pulse_next_s;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_BIT    (RESET_VALUE[g])
        ) u_bit (
            .clk_i        (clk),
            .reset_i      (reset),
            .tick_i       (tick_s),
            .bypass_i     (bypass),
            .sync_i       (sync2_q[g]),
            .state_o      (sw_out[g]),
            .rise_o       (rise[g]),
            .fall_o       (fall[g]),
            .pulse_next_o (pulse_next_s[g])
        );
    end

    assign change = change_q;

endmodule
